// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, JAL/branch
// predecode and a 2-bit saturating-counter branch history table.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        bht_upd_valid,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        PredTakenD,
  output logic        ValidD
);

  localparam int         IDX_W     = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic signed [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11)
      res = cnt + 2'b01;
    else if (!taken && cnt != 2'b00)
      res = cnt - 2'b01;
    return res;
  endfunction

  logic [31:0]        pc_p0;
  logic [31:0]        pc_plus4_p0;
  logic [31:0]        target_p0;
  logic [31:0]        pc_next_p0;
  logic signed [31:0] imm_p0;
  logic               pred_taken_p0;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   upd_idx;
  logic [1:0]         bht [BHT_ENTRIES];

  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc_plus4_p1;
  logic        pred_taken_p1;
  logic        vld_p1;

  logic unused_upd_bits;
  assign unused_upd_bits = ^{bht_upd_pc[31:IDX_W+2], bht_upd_pc[1:0]};

  assign rd_idx      = pc_p0[IDX_W+1:2];
  assign upd_idx     = bht_upd_pc[IDX_W+1:2];
  assign imem_addr   = pc_p0;
  assign pc_plus4_p0 = pc_p0 + 32'd4;

  // Predecode: the prediction reads the counter as it stands this cycle, so a
  // same-index update only becomes visible on the following fetch.
  always_comb begin
    pred_taken_p0 = 1'b0;
    imm_p0        = '0;
    unique case (imem_rdata[6:0])
      OP_JAL: begin
        pred_taken_p0 = 1'b1;
        imm_p0        = imm_j(imem_rdata);
      end
      OP_BRANCH: begin
        pred_taken_p0 = bht[rd_idx][1];
        imm_p0        = imm_b(imem_rdata);
      end
      default: ;
    endcase
  end

  assign target_p0 = pc_p0 + $unsigned(imm_p0);

  always_comb begin
    pc_next_p0 = pc_plus4_p0;
    if (redirect_valid)
      pc_next_p0 = redirect_pc;
    else if (stall_f)
      pc_next_p0 = pc_p0;
    else if (pred_taken_p0)
      pc_next_p0 = target_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_p0 <= RESET_PC;
    else
      pc_p0 <= pc_next_p0;
  end

  // BHT training is independent of stall and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= 2'b01;
    end else if (bht_upd_valid) begin
      bht[upd_idx] <= sat_update(bht[upd_idx], bht_upd_taken);
    end
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1      <= NOP_INSTR;
      pc_p1         <= '0;
      pc_plus4_p1   <= '0;
      pred_taken_p1 <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (redirect_valid || flush_d) begin
      instr_p1      <= NOP_INSTR;
      pc_p1         <= '0;
      pc_plus4_p1   <= '0;
      pred_taken_p1 <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (!stall_f) begin
      instr_p1      <= imem_rdata;
      pc_p1         <= pc_p0;
      pc_plus4_p1   <= pc_plus4_p0;
      pred_taken_p1 <= pred_taken_p0;
      vld_p1        <= 1'b1;
    end
  end

  assign InstrD     = instr_p1;
  assign PCD        = pc_p1;
  assign PCPlus4D   = pc_plus4_p1;
  assign PredTakenD = pred_taken_p1;
  assign ValidD     = vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected post-edge state,
// a monitor pops and compares after each rising edge (or on a mid-cycle strobe).
module tb_fetch_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        pt;
    logic        v;
    logic        chk2;
    logic [31:0] addr2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, flush_d, redirect_valid, bht_upd_valid, bht_upd_taken;
  logic [31:0] redirect_pc, bht_upd_pc;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        PredTakenD, ValidD;
  logic [31:0] imem_addr2, InstrD2, PCD2, PCPlus4D2;
  logic        PredTakenD2, ValidD2;
  logic        chk_strobe = 1'b0;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0200_006F;  // jal x0,+0x20
      32'h0000_0040: return 32'hFE00_0CE3;  // beq x0,x0,-8
      default:       return 32'h0000_0013;
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .PredTakenD(PredTakenD), .ValidD(ValidD)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall_f(1'b0), .flush_d(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .bht_upd_valid(1'b0), .bht_upd_pc(32'h0), .bht_upd_taken(1'b0),
    .imem_addr(imem_addr2), .imem_rdata(32'h0000_0013), .InstrD(InstrD2), .PCD(PCD2),
    .PCPlus4D(PCPlus4D2), .PredTakenD(PredTakenD2), .ValidD(ValidD2)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge chk_strobe) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("imem_addr", imem_addr, e.addr);
      cmp("InstrD", InstrD, e.instr);
      cmp("PCD", PCD, e.pcd);
      cmp("PCPlus4D", PCPlus4D, e.pc4);
      cmp("PredTakenD", {31'b0, PredTakenD}, {31'b0, e.pt});
      cmp("ValidD", {31'b0, ValidD}, {31'b0, e.v});
      if (e.chk2) cmp("wrap_imem_addr", imem_addr2, e.addr2);
    end
  end

  function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pcd, input logic [31:0] pc4,
                              input logic pt, input logic v);
    exp_t e;
    e.addr = addr; e.instr = instr; e.pcd = pcd; e.pc4 = pc4;
    e.pt = pt; e.v = v; e.chk2 = 1'b0; e.addr2 = '0;
    return e;
  endfunction

  function automatic exp_t bub(input logic [31:0] addr);
    return mk(addr, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  // Drive one cycle's inputs at the falling edge and queue the state expected
  // after the next rising edge.
  task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic ut, input exp_t e);
    @(negedge clk);
    stall_f = st; flush_d = fl; redirect_valid = rv; redirect_pc = rpc;
    bht_upd_valid = uv; bht_upd_pc = upc; bht_upd_taken = ut;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; stall_f = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; bht_upd_valid = 1'b0; bht_upd_pc = '0; bht_upd_taken = 1'b0;

    // Reset held
    e = bub(32'h0); e.chk2 = 1'b1; e.addr2 = 32'hFFFF_FFFC;
    step(0, 0, 0, 0, 0, 0, 0, e);
    // Release reset at a falling edge; wrap instance steps FFFFFFFC -> 0
    @(negedge clk);
    rst_n = 1'b1;
    e = mk(32'h4, 32'h13, 32'h0, 32'h4, 0, 1); e.chk2 = 1'b1; e.addr2 = 32'h0;
    q.push_back(e);
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h8, 32'h13, 32'h4, 32'h8, 0, 1));
    // Stall two cycles at PC=8
    step(1, 0, 0, 0, 0, 0, 0, mk(32'h8, 32'h13, 32'h4, 32'h8, 0, 1));
    step(1, 0, 0, 0, 0, 0, 0, mk(32'h8, 32'h13, 32'h4, 32'h8, 0, 1));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'hC, 32'h13, 32'h8, 32'hC, 0, 1));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h10, 32'h13, 32'hC, 32'h10, 0, 1));
    // JAL at 0x10 -> 0x30
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h30, 32'h0200_006F, 32'h10, 32'h14, 1, 1));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h34, 32'h13, 32'h30, 32'h34, 0, 1));
    // Branch at 0x40 with weakly not-taken counter
    step(0, 0, 1, 32'h40, 0, 0, 0, bub(32'h40));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h44, 32'hFE00_0CE3, 32'h40, 32'h44, 0, 1));
    // Two taken updates -> 11
    step(0, 0, 0, 0, 1, 32'h40, 1, mk(32'h48, 32'h13, 32'h44, 32'h48, 0, 1));
    step(0, 0, 0, 0, 1, 32'h40, 1, mk(32'h4C, 32'h13, 32'h48, 32'h4C, 0, 1));
    step(0, 0, 1, 32'h40, 0, 0, 0, bub(32'h40));
    // Predicted taken -> 0x38; not-taken update same cycle (11 -> 10)
    step(0, 0, 0, 0, 1, 32'h40, 0, mk(32'h38, 32'hFE00_0CE3, 32'h40, 32'h44, 1, 1));
    step(0, 0, 1, 32'h40, 0, 0, 0, bub(32'h40));
    // Counter 10 read while updated to 01: old value still predicts taken
    step(0, 0, 0, 0, 1, 32'h40, 0, mk(32'h38, 32'hFE00_0CE3, 32'h40, 32'h44, 1, 1));
    step(0, 0, 1, 32'h40, 1, 32'h40, 0, bub(32'h40));
    // Fourth not-taken update at 00 saturates
    step(0, 0, 0, 0, 1, 32'h40, 0, mk(32'h44, 32'hFE00_0CE3, 32'h40, 32'h44, 0, 1));
    // 00 + taken = 01, still not taken
    step(0, 0, 1, 32'h40, 1, 32'h40, 1, bub(32'h40));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h44, 32'hFE00_0CE3, 32'h40, 32'h44, 0, 1));
    // Redirect beats stall
    step(1, 0, 1, 32'h100, 0, 0, 0, bub(32'h100));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h104, 32'h13, 32'h100, 32'h104, 0, 1));
    // Flush with stall: PC holds, IF/ID bubbles; flush alone: PC advances
    step(1, 1, 0, 0, 0, 0, 0, bub(32'h104));
    step(0, 1, 0, 0, 0, 0, 0, bub(32'h108));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h10C, 32'h13, 32'h108, 32'h10C, 0, 1));
    // PC wrap and unaligned redirect
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, bub(32'hFFFF_FFFC));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h0, 32'h13, 32'hFFFF_FFFC, 32'h0, 0, 1));
    step(0, 0, 1, 32'h203, 0, 0, 0, bub(32'h203));
    step(0, 0, 0, 0, 0, 0, 0, mk(32'h207, 32'h13, 32'h203, 32'h207, 0, 1));
    // Async reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    e = bub(32'h0); e.chk2 = 1'b1; e.addr2 = 32'hFFFF_FFFC;
    q.push_back(e);
    chk_strobe = 1'b1;
    #2;
    chk_strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e = mk(32'h4, 32'h13, 32'h0, 32'h4, 0, 1); e.chk2 = 1'b1; e.addr2 = 32'h0;
    q.push_back(e);
    repeat (3) @(posedge clk);
    #2;
    cmp("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
